// File: rtl/muldiv_pkg.sv
// RV32M op codes, FSM states and constants.
// Shared with the control unit so the encodings cannot drift apart.
package muldiv_pkg;

    localparam logic [5:0] OP_MUL    = 6'b100111;
    localparam logic [5:0] OP_MULH   = 6'b101000;
    localparam logic [5:0] OP_MULHU  = 6'b101001;
    localparam logic [5:0] OP_MULHSU = 6'b101010;
    localparam logic [5:0] OP_DIV    = 6'b101011;
    localparam logic [5:0] OP_DIVU   = 6'b101100;
    localparam logic [5:0] OP_REM    = 6'b101101;
    localparam logic [5:0] OP_REMU   = 6'b101110;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_e;

    function automatic logic is_mul_op(input logic [5:0] c);
        return c inside {OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU};
    endfunction

    function automatic logic is_div_op(input logic [5:0] c);
        return c inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic [31:0] neg_if(input logic n,
                                           input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration, iterated by the muldiv_unit FSM.
// quo_i shifts dividend bits out at the top and quotient bits in at the bottom.
module restoring_div_step
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0]   shifted;
    logic [XLEN-1:0] sub;
    logic            ge;

    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign ge      = (shifted >= {1'b0, div_i});
    // when ge holds the difference is below div_i, so it fits in XLEN bits
    assign sub     = shifted[XLEN-1:0] - div_i;
    assign rem_o   = ge ? sub : shifted[XLEN-1:0];
    assign quo_o   = {quo_i[XLEN-2:0], ge};

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit beside the execute-stage ALU.
// Core stalls while busy and writes back on the one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_STEPS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      aluControl,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int            CW   = $clog2(DIV_STEPS);
    localparam logic [CW-1:0] LAST = CW'(DIV_STEPS - 1);

    state_e            state_q, state_d;
    logic [5:0]        op_q;
    logic [XLEN-1:0]   a_q, b_q, rem_q, spec_res_q;
    logic [XLEN-1:0]   result_q, result_d;
    logic [CW-1:0]     cnt_q;
    logic              neg_quo_q, neg_rem_q, spec_q;

    logic              accept, kill;
    logic              in_mul, in_sgn, in_rem, in_zero, in_ovf;
    logic [XLEN-1:0]   in_spec_res;
    logic [XLEN-1:0]   rem_nx, quo_nx;
    logic              a_sgn, b_sgn, op_rem;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;

    assign in_mul  = is_mul_op(aluControl);
    assign accept  = (state_q == S_IDLE) && start && !flush
                   && (in_mul || is_div_op(aluControl));
    assign in_sgn  = (aluControl == OP_DIV) || (aluControl == OP_REM);
    assign in_rem  = (aluControl == OP_REM) || (aluControl == OP_REMU);
    assign in_zero = (srcB == '0);
    assign in_ovf  = in_sgn && (srcA == INT_MIN) && (srcB == ALL_ONES);
    assign in_spec_res = in_zero ? (in_rem ? srcA : ALL_ONES)
                                 : (in_rem ? '0 : INT_MIN);
    assign kill    = flush && busy;

    assign a_sgn = (op_q != OP_MULHU);
    assign b_sgn = (op_q == OP_MUL) || (op_q == OP_MULH);
    assign mul_a = {{XLEN{a_sgn & a_q[XLEN-1]}}, a_q};
    assign mul_b = {{XLEN{b_sgn & b_q[XLEN-1]}}, b_q};
    assign prod  = mul_a * mul_b;
    assign op_rem = (op_q == OP_REM) || (op_q == OP_REMU);

    restoring_div_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (a_q),
        .div_i (b_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // special-case divides pass through FIX to keep a two-cycle latency
    always_comb begin
        state_d = state_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (in_mul)                 state_d = S_MUL;
                        else if (in_zero || in_ovf) state_d = S_FIX;
                        else                        state_d = S_DIV;
                    end
                end
                S_MUL:  state_d = S_DONE;
                S_DIV:  if (cnt_q == LAST) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == S_MUL) || (state_q == S_DIV)
            || (state_q == S_FIX);
        done = (state_q == S_DONE);
    end

    always_comb begin
        result_d = result_q;
        if (!kill && state_q == S_MUL) begin
            result_d = (op_q == OP_MUL) ? prod[XLEN-1:0]
                                        : prod[2*XLEN-1:XLEN];
        end else if (!kill && state_q == S_FIX) begin
            if (spec_q)      result_d = spec_res_q;
            else if (op_rem) result_d = neg_if(neg_rem_q, rem_q);
            else             result_d = neg_if(neg_quo_q, a_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            spec_res_q <= '0;
            result_q   <= '0;
            cnt_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            spec_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            if (accept) begin
                op_q       <= aluControl;
                cnt_q      <= '0;
                rem_q      <= '0;
                spec_q     <= in_zero || in_ovf;
                spec_res_q <= in_spec_res;
                neg_quo_q  <= in_sgn && (srcA[XLEN-1] ^ srcB[XLEN-1]);
                neg_rem_q  <= in_sgn && srcA[XLEN-1];
                a_q        <= neg_if(in_sgn && srcA[XLEN-1], srcA);
                b_q        <= neg_if(in_sgn && srcB[XLEN-1], srcB);
            end else if (state_q == S_DIV) begin
                rem_q <= rem_nx;
                a_q   <= quo_nx;
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Cycle T is the cycle whose closing edge accepts the request.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [5:0]  aluControl;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int pass_cnt  = 0;
    int total_cnt = 0;

    muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .aluControl (aluControl),
        .srcA       (srcA),
        .srcB       (srcB),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .result     (result)
    );

    always #5 clk = ~clk;

    // issues one request and returns the cycle index (T+cyc) of done
    task automatic run_op(input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc,
                          output logic [31:0] res, output logic bsy);
        @(negedge clk);
        start = 1'b1; aluControl = op; srcA = a; srcB = b;
        @(posedge clk); #1;
        bsy = busy;
        @(negedge clk);
        start = 1'b0; aluControl = 6'd0;
        cyc = -1; res = 32'hDEAD_BEEF;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = k + 1; res = result;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        aluControl = 6'd0; srcA = '0; srcB = '0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        int cyc; logic [31:0] r; logic b;
        run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, cyc, r, b);
        total_cnt++;
        if (b !== 1'b1) $display("FAIL mul_busy: got %b want 1", b);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 2) $display("FAIL mul_latency: got T+%0d want T+2", cyc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'hFFFF_FFEB) $display("FAIL mul: got %h want ffffffeb", r);
        else pass_cnt++;
        run_op(OP_MULH, 32'd7, 32'hFFFF_FFFD, cyc, r, b);
        total_cnt++;
        if (r !== 32'hFFFF_FFFF) $display("FAIL mulh: got %h want ffffffff", r);
        else pass_cnt++;
        run_op(OP_MULHU, 32'd7, 32'hFFFF_FFFD, cyc, r, b);
        total_cnt++;
        if (r !== 32'h0000_0006) $display("FAIL mulhu: got %h want 00000006", r);
        else pass_cnt++;
        run_op(OP_MULHSU, 32'hFFFF_FFFD, 32'd7, cyc, r, b);
        total_cnt++;
        if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu: got %h want ffffffff", r);
        else pass_cnt++;
    endtask

    task automatic test_div();
        int cyc; logic [31:0] r; logic b;
        run_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, cyc, r, b);
        total_cnt++;
        if (b !== 1'b1) $display("FAIL div_busy: got %b want 1", b);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 34) $display("FAIL div_latency: got T+%0d want T+34", cyc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'hFFFF_FFFA) $display("FAIL div: got %h want fffffffa", r);
        else pass_cnt++;
        run_op(OP_REM, 32'hFFFF_FFEC, 32'd3, cyc, r, b);
        total_cnt++;
        if (r !== 32'hFFFF_FFFE) $display("FAIL rem: got %h want fffffffe", r);
        else pass_cnt++;
        run_op(OP_DIVU, 32'd100, 32'd7, cyc, r, b);
        total_cnt++;
        if (r !== 32'd14) $display("FAIL divu: got %h want 0000000e", r);
        else pass_cnt++;
        run_op(OP_REMU, 32'd100, 32'd7, cyc, r, b);
        total_cnt++;
        if (r !== 32'd2) $display("FAIL remu: got %h want 00000002", r);
        else pass_cnt++;
    endtask

    task automatic test_special();
        int cyc; logic [31:0] r; logic b;
        run_op(OP_DIVU, 32'd5, 32'd0, cyc, r, b);
        total_cnt++;
        if (cyc !== 2) $display("FAIL div0_latency: got T+%0d want T+2", cyc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'hFFFF_FFFF) $display("FAIL divu0: got %h want ffffffff", r);
        else pass_cnt++;
        run_op(OP_REM, 32'd5, 32'd0, cyc, r, b);
        total_cnt++;
        if (r !== 32'd5) $display("FAIL rem0: got %h want 00000005", r);
        else pass_cnt++;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r, b);
        total_cnt++;
        if (r !== 32'h8000_0000) $display("FAIL div_ovf: got %h want 80000000", r);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 2) $display("FAIL ovf_latency: got T+%0d want T+2", cyc);
        else pass_cnt++;
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r, b);
        total_cnt++;
        if (r !== 32'h0) $display("FAIL rem_ovf: got %h want 00000000", r);
        else pass_cnt++;
        run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, cyc, r, b);
        total_cnt++;
        if (r !== 32'h8000_0000) $display("FAIL remu_big: got %h want 80000000", r);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        int cyc; int nd; logic [31:0] r; logic b; logic bsy_after;
        run_op(OP_MUL, 32'd5, 32'd5, cyc, r, b);
        total_cnt++;
        if (r !== 32'd25) $display("FAIL flush_pre: got %h want 00000019", r);
        else pass_cnt++;
        @(negedge clk);
        start = 1'b1; aluControl = OP_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; bsy_after = 1'bx;
        for (int k = 1; k <= 10; k++) begin
            if (k == 10) flush = 1'b1;
            @(posedge clk); #1;
            if (done) nd++;
            if (k == 10) bsy_after = busy;
            @(negedge clk);
            flush = 1'b0;
        end
        total_cnt++;
        if (bsy_after !== 1'b0) $display("FAIL flush_busy: got %b want 0", bsy_after);
        else pass_cnt++;
        total_cnt++;
        if (nd !== 0) $display("FAIL flush_done: got %0d pulses want 0", nd);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'd25) $display("FAIL flush_hold: got %h want 00000019", result);
        else pass_cnt++;
        run_op(OP_MUL, 32'd3, 32'd4, cyc, r, b);
        total_cnt++;
        if (cyc !== 2) $display("FAIL flush_next_lat: got T+%0d want T+2", cyc);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'd12) $display("FAIL flush_next: got %h want 0000000c", r);
        else pass_cnt++;
    endtask

    task automatic test_ignored();
        int nd; int first; logic [31:0] r; logic b1; logic b2;
        @(negedge clk);
        start = 1'b1; aluControl = OP_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        nd = 0; first = -1; r = 32'hDEAD_BEEF;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                start = 1'b1; aluControl = OP_MUL; srcA = 32'd3; srcB = 32'd4;
            end
            @(posedge clk); #1;
            if (done) begin
                nd++;
                if (first < 0) first = k + 1;
                r = result;
            end
            @(negedge clk);
            start = 1'b0;
        end
        total_cnt++;
        if (nd !== 1) $display("FAIL busy_start_pulses: got %0d want 1", nd);
        else pass_cnt++;
        total_cnt++;
        if (first !== 34) $display("FAIL busy_start_lat: got T+%0d want T+34", first);
        else pass_cnt++;
        total_cnt++;
        if (r !== 32'd14) $display("FAIL busy_start_res: got %h want 0000000e", r);
        else pass_cnt++;
        start = 1'b1; aluControl = 6'b000000; srcA = 32'd9; srcB = 32'd9;
        @(posedge clk); #1;
        b1 = busy;
        @(negedge clk);
        aluControl = OP_MUL; flush = 1'b1;
        @(posedge clk); #1;
        b2 = busy;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        total_cnt++;
        if (b1 !== 1'b0) $display("FAIL nonm_busy: got %b want 0", b1);
        else pass_cnt++;
        total_cnt++;
        if (b2 !== 1'b0) $display("FAIL flush_start_busy: got %b want 0", b2);
        else pass_cnt++;
        nd = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        total_cnt++;
        if (nd !== 0 || result !== 32'd14)
            $display("FAIL idle_ignored: got %0d pulses result %h want 0 and 0000000e", nd, result);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc; logic [31:0] r; logic b;
        @(negedge clk);
        start = 1'b1; aluControl = OP_DIVU; srcA = 32'd100; srcB = 32'd7;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", busy);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL arst_done: got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (result !== 32'h0) $display("FAIL arst_result: got %h want 0", result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_MUL, 32'd3, 32'd4, cyc, r, b);
        total_cnt++;
        if (r !== 32'd12 || cyc !== 2)
            $display("FAIL post_reset_mul: got %h at T+%0d want 0000000c at T+2", r, cyc);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
